// File: rtl/sha256_pkg.sv
// Shared types, IV, state encoding and FIPS 180-4 round helpers for the SHA-256 round core.
package sha256_pkg;

  typedef logic [31:0] word_t;

  // Field order puts a/H0 in the most significant word, matching the digest layout.
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } hash_t;

  localparam hash_t HashIv = '{
    a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
    e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
  };

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRound,
    StUpdate
  } state_e;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic hash_t sha_round(input hash_t s, input word_t k, input word_t w);
    word_t t1;
    word_t t2;
    hash_t r;
    t1  = s.h + big_sigma1(s.e) + ch(s.e, s.f, s.g) + k + w;
    t2  = big_sigma0(s.a) + maj(s.a, s.b, s.c);
    r.a = t1 + t2;
    r.b = s.a;
    r.c = s.b;
    r.d = s.c;
    r.e = s.d + t1;
    r.f = s.e;
    r.g = s.f;
    r.h = s.g;
    return r;
  endfunction

  function automatic hash_t hash_add(input hash_t x, input hash_t y);
    hash_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/sha256_w_sched.sv
// On-the-fly SHA-256 message schedule: 16-word window, newest word in slot 15.
module sha256_w_sched
  import sha256_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  shift,
  input  logic  use_data,
  input  word_t w_data,
  output word_t w_cur
);

  // Slot 15 holds W[t-1], slot 0 holds W[t-16].
  word_t [15:0] w_q;

  assign w_cur = use_data ? w_data
               : small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q <= '0;
    end else if (shift) begin
      w_q <= {w_cur, w_q[15:1]};
    end
  end

endmodule

// File: rtl/sha256_round_core.sv
// SHA-256 compression core, one round per cycle, K supplied by an external ROM.
// Define SHA256_CHAIN_EN to keep H across blocks and honour init.
module sha256_round_core
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         w_valid,
  output logic         w_ready,
  input  logic [31:0]  w_data,
  output logic         k_en,
  output logic [5:0]   k_addr,
  input  logic [31:0]  k_i,
  output logic         busy,
  output logic         digest_valid,
  output logic [255:0] digest
);

  state_e     state_q, state_d;
  logic       live_q;
  logic [5:0] t_q, t_d;
  hash_t      h_q, h_d;
  hash_t      work_q, work_d;
  hash_t      digest_q, digest_d;
  logic       dv_q;

  logic  accept;
  hash_t h_start;
  hash_t round_in;
  hash_t round_out;
  word_t w_cur;

`ifdef SHA256_CHAIN_EN
  assign h_start = init ? HashIv : h_q;
`else
  logic unused_init;
  assign unused_init = init;
  assign h_start     = HashIv;
`endif

  // live_q keeps the stream closed until the first edge after reset release.
  assign w_ready      = live_q && (state_q == StIdle || state_q == StLoad);
  assign accept       = w_valid && w_ready;
  assign round_in     = (state_q == StIdle) ? h_start : work_q;
  assign round_out    = sha_round(round_in, k_i, w_cur);
  assign busy         = (state_q != StIdle);
  assign digest_valid = dv_q;
  assign digest       = digest_q;

  sha256_w_sched u_w_sched (
    .clk      (clk),
    .rst      (rst),
    .shift    (accept || state_q == StRound),
    .use_data (state_q != StRound),
    .w_data   (w_data),
    .w_cur    (w_cur)
  );

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    h_d      = h_q;
    work_d   = work_q;
    digest_d = digest_q;
    k_en     = 1'b0;
    k_addr   = '0;
    unique case (state_q)
      StIdle: begin
        k_en   = live_q;
        h_d    = h_start;
        work_d = h_start;
        if (accept) begin
          work_d  = round_out;
          t_d     = 6'd1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        k_en   = 1'b1;
        k_addr = t_q;
        if (accept) begin
          work_d = round_out;
          t_d    = t_q + 6'd1;
          if (t_q == 6'd15) state_d = StRound;
        end
      end
      StRound: begin
        k_en   = 1'b1;
        k_addr = t_q;
        work_d = round_out;
        t_d    = t_q + 6'd1;
        if (t_q == 6'd63) state_d = StUpdate;
      end
      StUpdate: begin
        h_d      = hash_add(h_q, work_q);
        digest_d = hash_add(h_q, work_q);
        t_d      = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      live_q   <= 1'b0;
      t_q      <= '0;
      h_q      <= HashIv;
      work_q   <= HashIv;
      digest_q <= '0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      live_q   <= 1'b1;
      t_q      <= t_d;
      h_q      <= h_d;
      work_q   <= work_d;
      digest_q <= digest_d;
      dv_q     <= (state_q == StUpdate);
    end
  end

endmodule

// File: tb/tb_sha256_round_core.sv
// Randomised bench for sha256_round_core against a plain FIPS 180-4 model; K ROM modelled here.
module tb_sha256_round_core;

  typedef logic [31:0] blk_t [16];

  logic         clk = 1'b0;
  logic         rst;
  logic         init;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic         k_en;
  logic [5:0]   k_addr;
  logic [31:0]  k_i;
  logic         busy;
  logic         digest_valid;
  logic [255:0] digest;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] Iv =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] AbcDigest =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EmptyDigest =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic [31:0] ktab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [255:0] model_h = Iv;

  always #5 clk = ~clk;

  // Garbage when disabled so a core that uses k_i in UPDATE is caught.
  assign k_i = k_en ? ktab[k_addr] : 32'hdeadbeef;

  sha256_round_core dut (
    .clk          (clk),
    .rst          (rst),
    .init         (init),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .k_en         (k_en),
    .k_addr       (k_addr),
    .k_i          (k_i),
    .busy         (busy),
    .digest_valid (digest_valid),
    .digest       (digest)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input blk_t m);
    logic [31:0]  w [64];
    logic [31:0]  hv [8];
    logic [31:0]  v [8];
    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) hv[i] = hin[255 - 32 * i -: 32];
    v = hv;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + ktab[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32 * i -: 32] = hv[i] + v[i];
    return r;
  endfunction

  // Streams one block with random valid gaps, monitors K and returns the digest and latency.
  task automatic send_block(input blk_t m, input bit do_init, input int gap_pct,
                            output logic [255:0] got, output int edges, output bit k_ok);
    int idx = 0;
    int cyc = 0;
    k_ok = 1'b1;
    while (idx < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (w_ready && (k_addr != 6'(idx) || !k_en)) k_ok = 1'b0;
      w_valid = ($urandom_range(99) >= gap_pct);
      w_data  = m[idx];
      init    = do_init && (idx == 0);
      if (w_valid && w_ready) idx++;
    end
    if (idx < 16) check_eq("load_timeout", 256'(idx), 256'd16);
    @(negedge clk);
    w_valid = 1'b0;
    init    = 1'b0;
    cyc     = 1;
    while (!digest_valid && cyc < 100) begin
      if (cyc <= 48 && (k_addr != 6'(15 + cyc) || !k_en || w_ready || !busy)) k_ok = 1'b0;
      if (cyc == 49 && (k_en || !busy)) k_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    edges = cyc - 1;
    got   = digest;
  endtask

  // Runs a block and checks digest, latency and K sequencing against the model.
  task automatic run_block(input string tag, input blk_t m, input bit do_init, input int gap_pct);
    logic [255:0] got;
    logic [255:0] exp;
    int           edges;
    bit           k_ok;
`ifdef SHA256_CHAIN_EN
    if (do_init) model_h = Iv;
    exp = compress(model_h, m);
`else
    exp = compress(Iv, m);
`endif
    model_h = exp;
    send_block(m, do_init, gap_pct, got, edges, k_ok);
    check_eq({tag, "_digest"}, got, exp);
    check_eq({tag, "_latency"}, 256'(edges), 256'd49);
    check_eq({tag, "_k_seq"}, 256'(k_ok), 256'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_w_ready"}, 256'(w_ready), 256'd0);
    check_eq({tag, "_k_en"}, 256'(k_en), 256'd0);
    check_eq({tag, "_k_addr"}, 256'(k_addr), 256'd0);
    check_eq({tag, "_busy"}, 256'(busy), 256'd0);
    check_eq({tag, "_digest_valid"}, 256'(digest_valid), 256'd0);
    check_eq({tag, "_digest"}, digest, 256'd0);
  endtask

  initial begin
    blk_t         abc;
    blk_t         empty;
    blk_t         rnd;
    logic [255:0] held;
    rst     = 1'b1;
    init    = 1'b0;
    w_valid = 1'b0;
    w_data  = '0;
    for (int i = 0; i < 16; i++) begin
      abc[i]   = '0;
      empty[i] = '0;
    end
    abc[0]   = 32'h61626380;
    abc[15]  = 32'h00000018;
    empty[0] = 32'h80000000;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_w_ready", 256'(w_ready), 256'd1);

    run_block("abc", abc, 1'b1, 0);
    check_eq("abc_const", model_h, AbcDigest);
    held = digest;
    @(negedge clk);
    check_eq("dv_pulse", 256'(digest_valid), 256'd0);
    check_eq("digest_hold", digest, held);

    run_block("empty", empty, 1'b1, 0);
    check_eq("empty_const", model_h, EmptyDigest);

    run_block("abc_gaps", abc, 1'b1, 40);
    check_eq("abc_gaps_const", model_h, AbcDigest);

`ifdef SHA256_CHAIN_EN
    begin
      blk_t b1;
      blk_t b2;
      b1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
             32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
             32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h0};
      for (int i = 0; i < 16; i++) b2[i] = '0;
      b2[15] = 32'h000001c0;
      run_block("two_blk1", b1, 1'b1, 10);
      run_block("two_blk2", b2, 1'b0, 10);
      check_eq("two_blk_const", model_h,
               256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
    end
`endif

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 16; i++) rnd[i] = $urandom();
      run_block($sformatf("rand%0d", n), rnd, bit'($urandom_range(1)), $urandom_range(50));
    end

    // Abort a block halfway with an asynchronous reset.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w_valid = 1'b1;
      w_data  = $urandom();
    end
    @(negedge clk);
    w_valid = 1'b0;
    check_eq("mid_busy", 256'(busy), 256'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst     = 1'b0;
    model_h = Iv;
    repeat (2) @(negedge clk);
    run_block("abc_after_reset", abc, 1'b0, 20);
    check_eq("abc_after_reset_const", model_h, AbcDigest);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
